// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, clock-polarity/phase helpers, default word width.
package spi_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  // Idle level of sck for a given mode
  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Clock phase: 0 samples on the leading edge, 1 on the trailing edge
  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the received-word handshake toward downstream logic.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             sck;
  logic             cs;
  logic             mosi;
  logic             rdy;
  logic [WIDTH-1:0] data;

  modport slave  (input  sck, cs, mosi, output rdy, data);
  modport master (output sck, cs, mosi, input  rdy, data);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with rise/fall pulses
// derived from a previous-value register.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic prev_q;

  // Synchroniser chain and previous-value register; all reset to the idle level
  // so reset release never produces an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      level  <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_in;
      level  <= meta_q;
      prev_q <= level;
    end
  end

  // Single-cycle edge strobes on the synchronised level
  always_comb begin
    rise_c = level & ~prev_q;
    fall_c = ~level & prev_q;
  end

endmodule

// File: rtl/spi_slave.sv
// Receive-only SPI slave: oversamples sck/cs/mosi on clk, shifts MOSI MSB-first
// on the mode's sampling edge and presents each completed word with a one-cycle rdy.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE = 1,
  parameter int unsigned WIDTH    = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam logic        MODE_CPOL   = cpol(2'(SPI_MODE));
  localparam logic        MODE_CPHA   = cpha(2'(SPI_MODE));
  // Modes 0 and 3 sample on rising sck, modes 1 and 2 on falling sck
  localparam logic        SAMPLE_RISE = (MODE_CPOL == MODE_CPHA);
  localparam int unsigned CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SH_W        = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sck_s, sck_rise_c, sck_fall_c;
  logic cs_s, cs_rise_c, cs_fall_c;
  logic mosi_s, mosi_rise_c, mosi_fall_c;
  logic sample_c;
  logic unused_edges_c;

  logic [CNT_W-1:0] cnt_q;
  logic [SH_W-1:0]  shift_q;
  logic             rdy_q;
  logic [WIDTH-1:0] data_q;

  spi_sync_edge #(.RST_VAL(MODE_CPOL)) u_sync_sck (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.sck),
    .level    (sck_s),
    .rise_c   (sck_rise_c),
    .fall_c   (sck_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.cs),
    .level    (cs_s),
    .rise_c   (cs_rise_c),
    .fall_c   (cs_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.mosi),
    .level    (mosi_s),
    .rise_c   (mosi_rise_c),
    .fall_c   (mosi_fall_c)
  );

  // Pick the sampling edge for the configured mode
  always_comb begin
    sample_c       = SAMPLE_RISE ? sck_rise_c : sck_fall_c;
    unused_edges_c = ^{sck_s, cs_rise_c, cs_fall_c, mosi_rise_c, mosi_fall_c};
  end

  // Shift engine: cleared while deselected, word completes on the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (cs_s) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (sample_c) begin
        shift_q <= SH_W'({shift_q, mosi_s});
        if (cnt_q == LAST_BIT) begin
          data_q <= {shift_q, mosi_s};
          rdy_q  <= 1'b1;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.rdy  = rdy_q;
  assign bus.data = data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave in mode 1: bench-driven SPI master with
// two clk per sck half-period, rdy pulses logged by a monitor.
module tb_spi_slave;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         cyc     = 0;
  int         total   = 0;
  int         bad     = 0;
  int         pulses  = 0;
  int         rdy_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] rx_q[$];

  spi_slave_if #(.WIDTH(8)) bus ();

  spi_slave #(.SPI_MODE(1), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every clk cycle in which rdy is high
  always @(negedge clk) begin
    if (bus.rdy === 1'b1) begin
      pulses++;
      rdy_cyc = cyc;
      rx_q.push_back(bus.data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 1 master: launch on rising sck, slave samples on falling sck
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sck  = 1'b1;
      bus.mosi = b[7-i];
      idle(2);
      bus.sck  = 1'b0;
      fall_cyc = cyc;
      idle(2);
    end
  endtask

  // One byte in its own CS frame, checking count, value and latency
  task automatic frame1(input logic [7:0] b, input string tag);
    int p0;
    int n0;
    p0 = pulses;
    n0 = rx_q.size();
    bus.cs = 1'b0;
    idle(2);
    send_bits(b, 8);
    idle(4);
    bus.cs = 1'b1;
    idle(10);
    check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
    check({tag, "_rxdata"}, 32'(rx_q.size() > n0 ? rx_q[n0] : 8'hxx), 32'(b));
    check({tag, "_latency"}, 32'(rdy_cyc - fall_cyc), 32'd3);
    check({tag, "_held"}, 32'(bus.data), 32'(b));
  endtask

  initial begin
    logic [7:0] vec [6];
    int p0;
    int n0;
    vec = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA};

    // Reset with idle pins
    bus.sck  = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    reset    = 1'b1;
    idle(10);
    check("reset_rdy", 32'(bus.rdy), 32'd0);
    check("reset_data", 32'(bus.data), 32'd0);
    reset = 1'b0;
    idle(100);
    check("idle_no_rdy", 32'(pulses), 32'd0);

    // Single-byte frames
    for (int i = 0; i < 6; i++) begin
      frame1(vec[i], $sformatf("single%0d", i));
    end

    // Two bytes under one CS
    p0 = pulses;
    n0 = rx_q.size();
    bus.cs = 1'b0;
    idle(2);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    idle(4);
    bus.cs = 1'b1;
    idle(10);
    check("multi_pulses", 32'(pulses - p0), 32'd2);
    check("multi_first", 32'(rx_q.size() > n0 ? rx_q[n0] : 8'hxx), 32'h A5);
    check("multi_second", 32'(rx_q.size() > n0 + 1 ? rx_q[n0+1] : 8'hxx), 32'h3C);
    check("multi_held", 32'(bus.data), 32'h3C);

    // CS abort after 4 bits, then a full frame
    p0 = pulses;
    bus.cs = 1'b0;
    idle(2);
    send_bits(8'hB0, 4);
    idle(4);
    bus.cs = 1'b1;
    idle(10);
    check("abort_no_rdy", 32'(pulses - p0), 32'd0);
    check("abort_data_kept", 32'(bus.data), 32'h3C);
    frame1(8'hC3, "after_abort");

    // sck toggling while deselected
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      bus.mosi = 1'($urandom_range(1));
      bus.sck  = 1'b1;
      idle(2);
      bus.sck  = 1'b0;
      idle(2);
    end
    idle(10);
    check("cs_high_no_rdy", 32'(pulses - p0), 32'd0);
    check("cs_high_data", 32'(bus.data), 32'hC3);

    // Reset after 5 bits of a frame
    p0 = pulses;
    bus.cs = 1'b0;
    idle(2);
    send_bits(8'hFF, 5);
    reset  = 1'b1;
    bus.cs = 1'b1;
    idle(2);
    check("midreset_data", 32'(bus.data), 32'd0);
    check("midreset_rdy", 32'(bus.rdy), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(10);
    check("midreset_no_rdy", 32'(pulses - p0), 32'd0);
    frame1(8'h81, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Receive-only SPI slave that deserialises MOSI bytes into the system clock domain. It sits behind the chip-level SPI pins and feeds received bytes to the downstream register/command logic through a one-cycle `rdy` strobe plus a held `data` byte. All SPI inputs are treated as asynchronous and are oversampled by `clk`. There is no MISO path.

## Interface
- `SPI_MODE`, default 1: SPI mode 0..3; CPOL = mode[1], CPHA = mode[0].
- `WIDTH`, default 8: bits per word.
- `clk` in 1: system clock. Single clock domain; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sck` in 1: SPI clock from the master; asynchronous to `clk`.
- `cs` in 1: chip select, active-low; asynchronous.
- `mosi` in 1: serial data, MSB first; asynchronous.
- `rdy` out 1: one-`clk` pulse when a full word has been received.
- `data` out WIDTH: last complete word; held until the next word completes.

## Operation
- `sck`, `cs` and `mosi` each pass through a 2-flop synchroniser. A further `sck_prev` register provides edge detection.
- Sampling edge:
  - Modes 0 and 3 sample on the synchronised rising `sck` edge.
  - Modes 1 and 2 sample on the falling edge.
  - Default mode 1: the master launches data on rising `sck` and the slave samples on falling `sck`.
- While synchronised `cs` = 0, each sampling edge shifts synchronised `mosi` into the LSB of the shift register and increments the bit counter (0..WIDTH-1).
- On the sampling edge with counter = WIDTH-1:
  - `data` ← {shift[WIDTH-2:0], mosi_s}.
  - `rdy` = 1 for the next `clk` cycle only.
  - Counter wraps to 0, so consecutive words inside one CS frame are supported.
- While synchronised `cs` = 1:
  - Counter and shift register are held at 0.
  - `sck` edges are ignored.
  - `data` keeps its value; `rdy` = 0.
- CS deasserted mid-word: the partial word is discarded and no `rdy` is issued. The next frame starts again at bit 0.
- Reset (any time, including mid-word):
  - `rdy` = 0, `data` = 0, counter = 0, shift = 0.
  - Synchronisers reset to the idle level: `sck` = CPOL, `cs` = 1, `mosi` = 0.
  - No spurious edge is generated on reset release.

## Timing
- Input constraints:
  - `sck` high and low phases are each ≥ 2 `clk` periods (nominal `sck` = `clk`/4).
  - `mosi` is stable from ≥ 2 `clk` before until ≥ 1 `clk` after the sampling edge.
  - `cs` falls ≥ 2 `clk` before the first `sck` edge and rises ≥ 2 `clk` after the last sampling edge.
- Latency: `rdy` is high in the `clk` cycle starting at the 3rd rising `clk` after the last sampling `sck` edge at the pin (2 synchroniser stages + 1 output register).
- `data` updates on the same `clk` edge that raises `rdy`, is valid while `rdy` is high, and stays stable afterwards.
- Minimum spacing between `rdy` pulses is WIDTH × `sck` period. Back-to-back words never merge or drop.

## Structure
- Shared package `spi_pkg` holds:
  - the mode encoding constants (MODE0..MODE3);
  - helper functions `cpol(mode)` and `cpha(mode)`;
  - the default `WIDTH` = 8.
- One sub-module, `spi_sync_edge`: a 2-flop synchroniser plus previous-value register. It outputs the synchronised level and rise/fall pulses, has a reset-value parameter, and is instantiated for `sck`, `cs` and `mosi`.
- The bench drives the block with the existing `SPI_Master` model: `SPI_MODE` = 1, `CLKS_PER_HALF_BIT` = 2, CS driven by the bench.

## Test plan
- Reset: hold `reset` for 10 `clk` → `rdy` = 0, `data` = 0x00. After release with idle inputs, no `rdy` for 100 `clk`.
- Single-byte frames: send 0x00, 0x01, 0x80, 0xFF, 0x55, 0xAA, each in its own CS frame with 10 idle `clk` between frames → exactly one `rdy` pulse per frame, `data` equal to the sent byte, pulse 3 `clk` after the 8th falling `sck`.
- Multi-byte frame: 0xA5 then 0x3C under one CS low → two `rdy` pulses; `data` = 0xA5 then 0x3C.
- CS abort: 4 `sck` cycles, raise `cs`, then a new frame with 0xC3 → no `rdy` for the partial word; one `rdy` with `data` = 0xC3.
- `sck` activity with `cs` = 1: 16 `sck` cycles → no `rdy`; `data` unchanged.
- Mid-byte reset: assert `reset` after 5 bits, release, then send 0x81 → `data` = 0x00 while in reset; afterwards a single `rdy` with `data` = 0x81.
